// File: rtl/bmp_gray_engine.sv
// bmp_gray_engine: in-place BGR -> 8-bit luma conversion on the BMP byte RAM.
// Each pixel takes 8 cycles: 4 back-to-back reads (the 4th holds ren high so
// the R byte stays valid), one compute cycle, then 3 byte writes of the luma.
// Header bytes and row padding bytes are never addressed.
module bmp_gray_engine #(
    parameter int ADDR_WIDTH   = 20,
    parameter int BYTE_WIDTH   = 8,
    parameter int PIXEL_OFFSET = 54,
    parameter int IMG_WIDTH    = 512,
    parameter int IMG_HEIGHT   = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  RAM_ren,
    output logic                  RAM_wen,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic [BYTE_WIDTH-1:0] RAM_in,
    input  logic [BYTE_WIDTH-1:0] RAM_out
);

    localparam int ROW_PAD = (4 - (3 * IMG_WIDTH) % 4) % 4;
    localparam int COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0]      LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] PIX_STEP = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(3 + ROW_PAD);
    localparam logic [ADDR_WIDTH-1:0] PIX_BASE = ADDR_WIDTH'(PIXEL_OFFSET);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CALC, S_WR0, S_WR1, S_WR2, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pix_addr_q, pix_addr_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [BYTE_WIDTH-1:0]   b_q, b_d, g_q, g_d, r_q, r_d, gray_q, gray_d;
    logic [15:0]             luma_sum;
    logic                    last_col, last_pix;

    assign last_col = (col_q == LAST_COL);
    assign last_pix = last_col && (row_q == LAST_ROW);

    // Weights sum to 256, so the >>8 of the 16-bit sum always fits in a byte
    assign luma_sum = 16'd29  * 16'(b_q)
                    + 16'd150 * 16'(g_q)
                    + 16'd77  * 16'(r_q);

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pix_addr_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            b_q        <= '0;
            g_q        <= '0;
            r_q        <= '0;
            gray_q     <= '0;
        end else begin
            state_q    <= state_d;
            pix_addr_q <= pix_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            b_q        <= b_d;
            g_q        <= g_d;
            r_q        <= r_d;
            gray_q     <= gray_d;
        end
    end

    // Next-state logic: fixed 8-cycle pixel loop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_RD3;
            S_RD3:   state_d = S_CALC;
            S_CALC:  state_d = S_WR0;
            S_WR0:   state_d = S_WR1;
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = last_pix ? S_DONE : S_RD0;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: byte capture one cycle after each read, luma, pixel walk
    always_comb begin
        pix_addr_d = pix_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        b_d        = b_q;
        g_d        = g_q;
        r_d        = r_q;
        gray_d     = gray_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pix_addr_d = PIX_BASE;
                    col_d      = '0;
                    row_d      = '0;
                end
            end
            S_RD1:  b_d    = RAM_out;
            S_RD2:  g_d    = RAM_out;
            S_RD3:  r_d    = RAM_out;
            S_CALC: gray_d = BYTE_WIDTH'(luma_sum >> 8);
            S_WR2: begin
                if (!last_pix) begin
                    if (last_col) begin
                        pix_addr_d = pix_addr_q + ROW_STEP;
                        col_d      = '0;
                        row_d      = row_q + ROW_W'(1);
                    end else begin
                        pix_addr_d = pix_addr_q + PIX_STEP;
                        col_d      = col_q + COL_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; ren and wen live in disjoint states
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        RAM_ren  = 1'b0;
        RAM_wen  = 1'b0;
        RAM_addr = '0;
        RAM_in   = '0;
        case (state_q)
            S_RD0:  begin busy = 1'b1; RAM_ren = 1'b1; RAM_addr = pix_addr_q; end
            S_RD1:  begin busy = 1'b1; RAM_ren = 1'b1; RAM_addr = pix_addr_q + ADDR_WIDTH'(1); end
            S_RD2,
            S_RD3:  begin busy = 1'b1; RAM_ren = 1'b1; RAM_addr = pix_addr_q + ADDR_WIDTH'(2); end
            S_CALC: busy = 1'b1;
            S_WR0:  begin busy = 1'b1; RAM_wen = 1'b1; RAM_in = gray_q; RAM_addr = pix_addr_q; end
            S_WR1:  begin busy = 1'b1; RAM_wen = 1'b1; RAM_in = gray_q; RAM_addr = pix_addr_q + ADDR_WIDTH'(1); end
            S_WR2:  begin busy = 1'b1; RAM_wen = 1'b1; RAM_in = gray_q; RAM_addr = pix_addr_q + ADDR_WIDTH'(2); end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
